z80_bus_fabric: RTL and testbench

- Parametrised successor to the hard-wired chip-select priority mux in the Z80 system top.
- Sits between tv80s and N peripheral slaves. Takes per-slave address hits from addr_decoder and arbitrates them by fixed priority.
- Adds per-slave programmable wait states, a slave-ready handshake, a bus-timeout watchdog, and unmapped/timeout error capture.
- Drives the CPU wait_n line; the current design ties it high.

---
 rtl/z80_bus_fabric_pkg.sv | 23 ++
 rtl/z80_bus_fabric_prio_enc.sv | 31 +++
 rtl/z80_bus_fabric.sv | 190 +++++++++++++++++++
 tb/tb_z80_bus_fabric.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/z80_bus_fabric_pkg.sv
// z80_bus_pkg: shared definitions for the Z80 bus fabric.
//   bus_state_e   - access FSM states (IDLE, WAIT, DONE)
//   DEFAULT_DATA  - read value for unmapped, idle or timed-out accesses
//   ROM..ADDR_DEC - slave port indices; a lower index has higher priority
package z80_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } bus_state_e;

    localparam logic [7:0] DEFAULT_DATA = 8'hFF;

    localparam int unsigned ROM      = 0;
    localparam int unsigned RAM      = 1;
    localparam int unsigned UART     = 2;
    localparam int unsigned LED      = 3;
    localparam int unsigned GPIO     = 4;
    localparam int unsigned USB      = 5;
    localparam int unsigned ADDR_DEC = 6;

endpackage

// File: rtl/z80_bus_fabric_prio_enc.sv
// bus_prio_enc: lowest-index-wins one-hot priority encoder.
// Ports:
//   req   in  WIDTH  request vector
//   grant out WIDTH  one-hot grant for the lowest set bit of req (0 if none)
//   any   out 1      at least one request is set
module bus_prio_enc
    import z80_bus_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grant,
    output logic             any
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (req[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/z80_bus_fabric.sv
// z80_bus_fabric: fixed-priority chip-select fabric between the tv80s CPU and
// NUM_SLAVES peripherals, with per-slave wait states, slave-ready handshake,
// bus-timeout watchdog and unmapped/timeout error capture.
// Ports:
//   clk_i, rst_n_i       clock, synchronous active-low reset
//   mreq_n, ioreq_n      CPU memory / IO request
//   rd_n, wr_n           CPU read / write strobes
//   addr_i               CPU address (captured on error)
//   slv_hit_i            per-slave decode hits
//   slv_wait_i           per-slave wait-state counts, WAIT_W bits each
//   slv_ready_i          per-slave ready
//   slv_data_i           per-slave read data, DATA_W bits each
//   cs_o                 one-hot chip selects
//   wait_n_o             CPU wait_n, low while stalling the access
//   data_o               CPU read data
//   err_o                one-cycle error pulse
//   err_addr_o, err_io_o, err_tmo_o  details of the last error
module z80_bus_fabric #(
    parameter int unsigned       NUM_SLAVES   = 8,
    parameter int unsigned       DATA_W       = 8,
    parameter int unsigned       ADDR_W       = 16,
    parameter int unsigned       WAIT_W       = 4,
    parameter int unsigned       TMO_W        = 8,
    parameter logic [DATA_W-1:0] DEFAULT_DATA = DATA_W'(z80_bus_pkg::DEFAULT_DATA)
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         mreq_n,
    input  logic                         ioreq_n,
    input  logic                         rd_n,
    input  logic                         wr_n,
    input  logic [ADDR_W-1:0]            addr_i,
    input  logic [NUM_SLAVES-1:0]        slv_hit_i,
    input  logic [NUM_SLAVES*WAIT_W-1:0] slv_wait_i,
    input  logic [NUM_SLAVES-1:0]        slv_ready_i,
    input  logic [NUM_SLAVES*DATA_W-1:0] slv_data_i,
    output logic [NUM_SLAVES-1:0]        cs_o,
    output logic                         wait_n_o,
    output logic [DATA_W-1:0]            data_o,
    output logic                         err_o,
    output logic [ADDR_W-1:0]            err_addr_o,
    output logic                         err_io_o,
    output logic                         err_tmo_o
);

    import z80_bus_pkg::*;

    bus_state_e              state, state_n;
    logic [NUM_SLAVES-1:0]   sel, sel_n;
    logic [NUM_SLAVES-1:0]   hit;
    logic                    hit_any;
    logic [WAIT_W-1:0]       cnt, cnt_n, cnt_dec, hit_wait;
    logic [TMO_W-1:0]        tmo, tmo_n, tmo_inc;
    logic                    tmo_flag, tmo_flag_n;
    logic                    err, err_n;
    logic [ADDR_W-1:0]       err_addr, err_addr_n;
    logic                    err_io, err_io_n;
    logic                    err_tmo, err_tmo_n;
    logic                    access;
    logic                    hit_ready, sel_ready;
    logic [DATA_W-1:0]       rdata;

    assign access = (!mreq_n || !ioreq_n) && (!rd_n || !wr_n);

    bus_prio_enc #(
        .WIDTH(NUM_SLAVES)
    ) u_prio_enc (
        .req  (slv_hit_i & {NUM_SLAVES{access}}),
        .grant(hit),
        .any  (hit_any)
    );

    // One-hot selects make these AND-OR muxes rather than indexed lookups.
    always_comb begin
        hit_wait = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (hit[k]) hit_wait = hit_wait | slv_wait_i[k*WAIT_W +: WAIT_W];
        end
    end

    assign hit_ready = |(hit & slv_ready_i);
    assign sel_ready = |(sel & slv_ready_i);

    assign cnt_dec = (cnt != '0) ? cnt - WAIT_W'(1) : '0;
    assign tmo_inc = tmo + TMO_W'(1);

    always_comb begin
        state_n    = state;
        sel_n      = sel;
        cnt_n      = cnt;
        tmo_n      = tmo;
        tmo_flag_n = tmo_flag;
        err_n      = 1'b0;
        err_addr_n = err_addr;
        err_io_n   = err_io;
        err_tmo_n  = err_tmo;
        case (state)
            IDLE: begin
                if (access) begin
                    if (!hit_any) begin
                        err_n      = 1'b1;
                        err_addr_n = addr_i;
                        err_io_n   = !ioreq_n;
                        err_tmo_n  = 1'b0;
                        sel_n      = '0;
                        state_n    = DONE;
                    end else begin
                        sel_n      = hit;
                        cnt_n      = hit_wait;
                        tmo_n      = '0;
                        tmo_flag_n = 1'b0;
                        state_n    = (hit_wait == '0 && hit_ready) ? DONE : WAIT;
                    end
                end
            end
            WAIT: begin
                // Exit is judged on the post-decrement count so that a count
                // of N holds wait_n low for exactly N cycles.
                cnt_n = cnt_dec;
                tmo_n = tmo_inc;
                if (cnt_dec == '0 && sel_ready) begin
                    state_n = DONE;
                end else if (tmo_inc == '1) begin
                    state_n    = DONE;
                    tmo_flag_n = 1'b1;
                    err_n      = 1'b1;
                    err_addr_n = addr_i;
                    err_io_n   = !ioreq_n;
                    err_tmo_n  = 1'b1;
                end
            end
            DONE: begin
                if (!access) begin
                    state_n    = IDLE;
                    tmo_flag_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            sel      <= '0;
            cnt      <= '0;
            tmo      <= '0;
            tmo_flag <= 1'b0;
            err      <= 1'b0;
            err_addr <= '0;
            err_io   <= 1'b0;
            err_tmo  <= 1'b0;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            cnt      <= cnt_n;
            tmo      <= tmo_n;
            tmo_flag <= tmo_flag_n;
            err      <= err_n;
            err_addr <= err_addr_n;
            err_io   <= err_io_n;
            err_tmo  <= err_tmo_n;
        end
    end

    // Combinational select in IDLE lets zero-wait slaves respond in the
    // address cycle; afterwards the latched select holds until DONE ends.
    always_comb begin
        if (!rst_n_i)          cs_o = '0;
        else if (state == IDLE) cs_o = hit;
        else                   cs_o = sel;
    end

    always_comb begin
        rdata = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (cs_o[k]) rdata = rdata | slv_data_i[k*DATA_W +: DATA_W];
        end
    end

    // Writes, unmapped cycles and timed-out accesses return the default.
    assign data_o = (cs_o != '0 && !tmo_flag && !rd_n) ? rdata : DEFAULT_DATA;

    assign wait_n_o   = (state != WAIT);
    assign err_o      = err;
    assign err_addr_o = err_addr;
    assign err_io_o   = err_io;
    assign err_tmo_o  = err_tmo;

endmodule

// File: tb/tb_z80_bus_fabric.sv
module tb_z80_bus_fabric;
    import z80_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mreq_n, ioreq_n, rd_n, wr_n;
    logic [15:0] addr;
    logic [7:0]  slv_hit;
    logic [31:0] slv_wait;
    logic [7:0]  slv_ready;
    logic [63:0] slv_data;
    logic [7:0]  cs;
    logic        wait_n;
    logic [7:0]  data;
    logic        err;
    logic [15:0] err_addr;
    logic        err_io, err_tmo;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    z80_bus_fabric dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .mreq_n     (mreq_n),
        .ioreq_n    (ioreq_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .addr_i     (addr),
        .slv_hit_i  (slv_hit),
        .slv_wait_i (slv_wait),
        .slv_ready_i(slv_ready),
        .slv_data_i (slv_data),
        .cs_o       (cs),
        .wait_n_o   (wait_n),
        .data_o     (data),
        .err_o      (err),
        .err_addr_o (err_addr),
        .err_io_o   (err_io),
        .err_tmo_o  (err_tmo)
    );

    typedef struct {
        string       name;
        logic [7:0]  cs;
        int          low;
        int          errs;
        logic        chk_data;
        logic [7:0]  data;
        logic [15:0] ea;
        logic        eio;
        logic        etmo;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: accumulates per-access observations and scores them against
    // the queued expectation when the access ends.
    logic       active = 1'b0;
    int         m_low, m_errs;
    logic [7:0] m_cs, m_data;
    logic       m_cs_bad;

    always @(negedge clk) begin
        logic acc;
        exp_t e;
        acc = (!mreq_n || !ioreq_n) && (!rd_n || !wr_n);
        if (acc) begin
            if (!active) begin
                active   = 1'b1;
                m_low    = 0;
                m_errs   = 0;
                m_cs     = cs;
                m_cs_bad = 1'b0;
                m_data   = 8'hxx;
            end else if (rst_n && cs !== m_cs) begin
                m_cs_bad = 1'b1;
            end
            if (!wait_n) m_low++;
            if (err) m_errs++;
            if (wait_n && rst_n) m_data = data;
        end else if (active) begin
            active = 1'b0;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL scoreboard: got an access with no expectation queued");
            end else begin
                e = exp_q.pop_front();
                chk({e.name, " cs"}, 32'(m_cs), 32'(e.cs));
                chk({e.name, " cs_stable"}, 32'(m_cs_bad), 32'd0);
                chk({e.name, " wait_low"}, 32'(m_low), 32'(e.low));
                chk({e.name, " err_pulses"}, 32'(m_errs), 32'(e.errs));
                if (e.chk_data) chk({e.name, " data"}, 32'(m_data), 32'(e.data));
                chk({e.name, " err_addr"}, 32'(err_addr), 32'(e.ea));
                chk({e.name, " err_io"}, 32'(err_io), 32'(e.eio));
                chk({e.name, " err_tmo"}, 32'(err_tmo), 32'(e.etmo));
            end
        end
    end

    task automatic expect_acc(input string name, input logic [7:0] ecs, input int low,
                              input int errs, input logic cd, input logic [7:0] ed,
                              input logic [15:0] ea, input logic eio, input logic etmo);
        exp_t e;
        e.name = name; e.cs = ecs; e.low = low; e.errs = errs; e.chk_data = cd;
        e.data = ed; e.ea = ea; e.eio = eio; e.etmo = etmo;
        exp_q.push_back(e);
    endtask

    task automatic deassert();
        mreq_n = 1'b1; ioreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; slv_hit = '0;
    endtask

    // Runs one CPU cycle; ready_after raises slave 5 ready after that many
    // observed wait cycles, rst_after asserts reset after that many.
    task automatic run(input logic [7:0] hit, input logic [15:0] a, input logic m,
                       input logic io, input logic rd, input int ready_after,
                       input int rst_after);
        int   low;
        logic done, aborted;
        @(posedge clk); #1;
        slv_hit = hit; addr = a; mreq_n = !m; ioreq_n = !io; rd_n = !rd; wr_n = rd;
        low = 0; done = 1'b0; aborted = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge clk); #1;
            if (!wait_n) begin
                low++;
                if (low == ready_after) slv_ready[USB] = 1'b1;
                if (low == rst_after) begin
                    rst_n = 1'b0;
                    @(posedge clk); #1;
                    chk("rst_mid cs", 32'(cs), 32'd0);
                    chk("rst_mid wait_n", 32'(wait_n), 32'd1);
                    chk("rst_mid data", 32'(data), 32'hFF);
                    chk("rst_mid err", 32'(err), 32'd0);
                    rst_n = 1'b1;
                    deassert();
                    aborted = 1'b1;
                    done = 1'b1;
                end
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL wait_bound: got wait_n stuck low expected release within 400 cycles");
            deassert();
        end else if (!aborted) begin
            @(posedge clk); #1;
            deassert();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        deassert();
        addr      = '0;
        slv_wait  = 32'h0010_0300;          // UART=3, USB=1, others 0
        slv_ready = 8'hD7;                  // LED and USB not ready
        slv_data  = 64'h8866_3C99_77C3_5A11;
        repeat (3) @(posedge clk);
        #1;
        chk("reset cs", 32'(cs), 32'd0);
        chk("reset wait_n", 32'(wait_n), 32'd1);
        chk("reset data", 32'(data), 32'hFF);
        chk("reset err", 32'(err), 32'd0);
        chk("reset err_addr", 32'(err_addr), 32'd0);
        chk("reset err_tmo", 32'(err_tmo), 32'd0);
        rst_n = 1'b1;

        expect_acc("t1_ram0ws", 8'h02, 0, 0, 1'b1, 8'h5A, 16'h0000, 1'b0, 1'b0);
        run(8'(1) << RAM, 16'h8000, 1'b1, 1'b0, 1'b1, 0, 0);

        expect_acc("t2_uart3ws", 8'h04, 3, 0, 1'b1, 8'hC3, 16'h0000, 1'b0, 1'b0);
        run(8'(1) << UART, 16'h0010, 1'b0, 1'b1, 1'b1, 0, 0);

        expect_acc("t3_usb_ready", 8'h20, 11, 0, 1'b1, 8'h3C, 16'h0000, 1'b0, 1'b0);
        run(8'(1) << USB, 16'h0020, 1'b0, 1'b1, 1'b1, 11, 0);

        expect_acc("t4_multihit", 8'h02, 0, 0, 1'b1, 8'h5A, 16'h0000, 1'b0, 1'b0);
        run(8'b0000_0110, 16'h8001, 1'b1, 1'b0, 1'b1, 0, 0);

        expect_acc("t5_unmapped", 8'h00, 0, 1, 1'b1, 8'hFF, 16'h1234, 1'b0, 1'b0);
        run(8'h00, 16'h1234, 1'b1, 1'b0, 1'b1, 0, 0);

        expect_acc("t6_unmapped_io", 8'h00, 0, 1, 1'b1, 8'hFF, 16'h00AB, 1'b1, 1'b0);
        run(8'h00, 16'h00AB, 1'b1, 1'b1, 1'b0, 0, 0);

        expect_acc("t7_gpio_write", 8'h10, 0, 0, 1'b1, 8'hFF, 16'h00AB, 1'b1, 1'b0);
        run(8'(1) << GPIO, 16'hC000, 1'b1, 1'b0, 1'b0, 0, 0);

        expect_acc("t8_timeout", 8'h08, 255, 1, 1'b1, 8'hFF, 16'h4000, 1'b0, 1'b1);
        run(8'(1) << LED, 16'h4000, 1'b1, 1'b0, 1'b1, 0, 0);

        expect_acc("t9_reset_wait", 8'h08, 20, 0, 1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0);
        run(8'(1) << LED, 16'h4001, 1'b1, 1'b0, 1'b1, 0, 20);

        expect_acc("t10_recover", 8'h02, 0, 0, 1'b1, 8'h5A, 16'h0000, 1'b0, 1'b0);
        run(8'(1) << RAM, 16'h8002, 1'b1, 1'b0, 1'b1, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
